// File: rtl/alu_mdu_unit.sv
// Execute unit: single-cycle RV32I integer ALU plus iterative radix-2 multiply/divide (M extension).
// Operands are taken on a valid/ready handshake; the registered result is held until consumed.
`timescale 1ns/1ps
module alu_mdu_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      op_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_reg, state_next;

  logic [XLEN-1:0]   result_reg;
  logic              zero_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   b_reg;
  logic [2:0]        op_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;

  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   imm_res;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   fin_res;
  logic [SH_W-1:0]   shamt;
  logic              is_mul, is_div;
  logic              div_by_zero, div_ovf, div_special, start_iter;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_tmp, div_diff;
  logic [2*XLEN-1:0] mul_acc, div_acc, step_acc, prod_fix;
  logic [XLEN-1:0]   quo_mag, rem_mag;
  logic              last_iter;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == BUSY);
  assign result    = result_reg;
  assign zero      = zero_reg;

  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op_sel)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  // Codes 16..19 multiply, 20..23 divide; bit0 set means the unsigned divide flavour.
  assign is_mul = (op_sel[4:2] == 3'b100);
  assign is_div = (op_sel[4:2] == 3'b101);

  assign div_by_zero = is_div && (op_b == '0);
  assign div_ovf     = is_div && !op_sel[0] && (op_a == SIGN_MIN) && (op_b == '1);
  assign div_special = div_by_zero || div_ovf;
  assign start_iter  = is_mul || (is_div && !div_special);

  always_comb begin
    special_res = '0;
    if (div_by_zero)
      special_res = op_sel[1] ? op_a : '1;
    else if (div_ovf)
      special_res = op_sel[1] ? '0 : op_a;
  end

  assign imm_res = div_special ? special_res : alu_res;

  // MUL/MULH treat both operands as signed, MULHSU only op_a, MULHU neither.
  assign a_signed = (is_mul && (op_sel[1:0] != 2'b11)) || (is_div && !op_sel[0]);
  assign b_signed = (is_mul && !op_sel[1]) || (is_div && !op_sel[0]);
  assign a_neg    = a_signed && op_a[XLEN-1];
  assign b_neg    = b_signed && op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;

  // acc_reg holds {partial product, remaining multiplier} or {remainder, remaining dividend/quotient}.
  assign mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
  assign mul_acc = {mul_sum, acc_reg[XLEN-1:1]};

  assign div_tmp  = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff = div_tmp - {1'b0, b_reg};
  assign div_acc  = div_diff[XLEN] ? {div_tmp[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};

  assign step_acc  = op_reg[2] ? div_acc : mul_acc;
  assign last_iter = (cnt_reg == LAST_ITER);

  assign prod_fix = neg_q_reg ? -step_acc : step_acc;
  assign quo_mag  = step_acc[XLEN-1:0];
  assign rem_mag  = step_acc[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = '0;
    if (!op_reg[2])
      fin_res = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (op_reg[1])
      fin_res = neg_r_reg ? -rem_mag : rem_mag;
    else
      fin_res = neg_q_reg ? -quo_mag : quo_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = start_iter ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      zero_reg   <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (start_iter) begin
              acc_reg   <= {{XLEN{1'b0}}, a_mag};
              b_reg     <= b_mag;
              op_reg    <= op_sel[2:0];
              neg_q_reg <= a_neg ^ b_neg;
              neg_r_reg <= a_neg;
              cnt_reg   <= '0;
            end else begin
              result_reg <= imm_res;
              zero_reg   <= (imm_res == '0);
            end
          end
        end
        BUSY: begin
          acc_reg <= step_acc;
          if (last_iter) begin
            cnt_reg    <= '0;
            result_reg <= fin_res;
            zero_reg   <= (fin_res == '0);
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed bench for alu_mdu_unit: ALU ops, iterative MUL/DIV, divide special cases,
// result hold under back-pressure, flush and asynchronous reset during an iterative op.
`timescale 1ns/1ps
module tb_alu_mdu_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  op_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_mdu_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one op for exactly one accept edge, then scramble the operand inputs.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    op_sel = op; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = ~a; op_b = ~b; op_sel = 5'd2;
  endtask

  // Latency counts edges from the accept edge (1) to the first edge after which out_valid is seen.
  task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
    int lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovld0"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    issue(tag, op, a, b);
    wait_result(tag, exp, exp_lat);
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    // Reset state
    #12;
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_inready", {31'd0, in_ready}, 32'd1);

    // ALU ops
    run_op("add_wrap", 5'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    run_op("sub_eq",   5'd3, 32'd5, 32'd5, 32'h0000_0000, 1);
    run_op("and",      5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run_op("or",       5'd1, 32'hF000_0001, 32'h000F_0010, 32'hF00F_0011, 1);
    run_op("xor",      5'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1);
    run_op("sll",      5'd5, 32'h0000_0001, 32'd35, 32'h0000_0008, 1);
    run_op("srl",      5'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run_op("sra",      5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run_op("slt",      5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu",     5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("unknown",  5'd12, 32'd9, 32'd9, 32'd0, 1);

    // Iterative multiply
    run_op("mulh",   5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhu",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul",    5'd16, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 33);
    run_op("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

    // Divide special cases (no iteration)
    run_op("div_z",   5'd20, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_z",  5'd23, 32'd7, 32'd0, 32'd7, 1);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Iterative divide
    run_op("div_neg", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("divu",    5'd21, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",    5'd23, 32'd100, 32'd7, 32'd2, 33);

    // REM -7 % 2 with result held under back-pressure
    issue("rem_hold", 5'd22, 32'hFFFF_FFF9, 32'd2);
    wait_result("rem_hold", 32'hFFFF_FFFF, 33);
    held = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_res", result, held);
      check("hold_ovalid", {31'd0, out_valid}, 32'd1);
      check("hold_inready", {31'd0, in_ready}, 32'd0);
    end
    consume("rem_hold");
    check("hold_keep_res", result, held);
    check("hold_inready1", {31'd0, in_ready}, 32'd1);

    // Flush during an iterative divide
    issue("flush_divu", 5'd21, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_ovalid", {31'd0, out_valid}, 32'd0);
    check("flush_inready", {31'd0, in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("flush_quiet", {31'd0, out_valid}, 32'd0);
    run_op("post_flush", 5'd2, 32'd2, 32'd3, 32'd5, 1);

    // Flush beats in_valid in the same cycle
    @(negedge clk);
    op_sel = 5'd2; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_win_ovld", {31'd0, out_valid}, 32'd0);
    check("flush_win_rdy", {31'd0, in_ready}, 32'd1);
    check("flush_win_res", result, 32'd5);

    // Asynchronous reset during an iterative divide
    issue("rst_divu", 5'd21, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_ovalid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 5'd2, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
